axis_rx_frame_gate: RTL and testbench



---
 rtl/axis_rx_frame_gate.sv | 133 +++++++++++++
 tb/tb_axis_rx_frame_gate.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_frame_gate.sv
// axis_rx_frame_gate: whole-frame enable gate with timestamp prepend and frame statistics
module axis_rx_frame_gate #(
  parameter int DATA_WIDTH = 8,
  parameter int TS_WIDTH = 64,
  parameter int TS_ENABLE = 1,
  parameter int USER_WIDTH = 1,
  parameter int COUNT_WIDTH = 32,
  parameter int RESYNC_GAP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [TS_WIDTH-1:0]    ts,
  input  logic                   clear_counters,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] drop_count,
  output logic [COUNT_WIDTH-1:0] error_count
);
  localparam int N = TS_ENABLE != 0 ? TS_WIDTH / DATA_WIDTH : 0;
  localparam int NL = N > 0 ? N : 1;
  localparam int FW = $clog2(NL + 1);
  localparam int GW = $clog2(RESYNC_GAP + 1);
  typedef enum logic [2:0] {RESYNC, IDLE, DISABLED, PASS, FLUSH, DROP} state_t;
  state_t state, rest;
  logic [DATA_WIDTH-1:0] dl_data [NL];
  logic                  dl_last [NL];
  logic [USER_WIDTH-1:0] dl_user [NL];
  logic [FW-1:0] fcnt;
  logic [GW-1:0] gap;
  logic late_drop, beat, fin, load, shift, emit, o_last, ld_nxt, drop_inc, frame_inc;
  logic [DATA_WIDTH-1:0] o_data;
  logic [USER_WIDTH-1:0] user_in, o_user;
  // Beat qualification and the source of the next output beat
  always_comb begin
    beat = s_axis_tvalid;
    fin = beat && s_axis_tlast;
    rest = enable ? IDLE : DISABLED;
    user_in = s_axis_tlast ? s_axis_tuser : '0;
    load = state == IDLE && beat;
    shift = (state == PASS && beat) || state == FLUSH;
    emit = load || shift;
    o_data = N == 0 ? s_axis_tdata : load ? ts[DATA_WIDTH-1:0] : dl_data[0];
    o_last = N == 0 ? s_axis_tlast : !load && dl_last[0];
    o_user = N == 0 ? user_in : load ? '0 : dl_user[0];
    ld_nxt = fin ? 1'b0 : beat || late_drop;
    drop_inc = fin && (state == DISABLED || state == DROP || state == FLUSH);
    frame_inc = emit && o_last;
  end
  // Frame state machine and registered output stage
  always_ff @(posedge clk)
    if (rst) begin
      state <= RESYNC;
      gap <= '0;
      fcnt <= '0;
      late_drop <= 1'b0;
      busy <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= '0;
    end else begin
      m_axis_tvalid <= emit;
      m_axis_tdata <= emit ? o_data : '0;
      m_axis_tlast <= emit && o_last;
      m_axis_tuser <= emit && o_last ? o_user : '0;
      case (state)
        RESYNC: begin
          gap <= beat ? '0 : gap + 1'b1;
          if (fin || (!beat && gap == GW'(RESYNC_GAP - 1))) state <= rest;
        end
        IDLE: if (beat) begin
          state <= !s_axis_tlast ? PASS : N > 0 ? FLUSH : rest;
          busy <= N > 0 || !s_axis_tlast;
          fcnt <= FW'(NL - 1);
        end else if (!enable) state <= DISABLED;
        DISABLED: if (beat) state <= s_axis_tlast ? rest : DROP;
          else if (enable) state <= IDLE;
        PASS: if (fin) begin
          state <= N > 0 ? FLUSH : rest;
          busy <= N > 0;
          fcnt <= FW'(NL - 1);
        end
        FLUSH: begin
          fcnt <= fcnt - 1'b1;
          late_drop <= fcnt == '0 ? 1'b0 : ld_nxt;
          if (fcnt == '0) begin
            state <= ld_nxt ? DROP : rest;
            busy <= 1'b0;
          end
        end
        DROP: if (fin) state <= rest;
        default: state <= RESYNC;
      endcase
    end
  // Delay line primed with the timestamp chunks at frame start, drained through FLUSH
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        dl_data[i] <= '0;
        dl_last[i] <= 1'b0;
        dl_user[i] <= '0;
      end
    end else if (load || shift) begin
      for (int i = 0; i < NL - 1; i++) begin
        dl_data[i] <= load ? ts[(i + 1) * DATA_WIDTH +: DATA_WIDTH] : dl_data[i + 1];
        dl_last[i] <= !load && dl_last[i + 1];
        dl_user[i] <= load ? '0 : dl_user[i + 1];
      end
      dl_data[NL - 1] <= state == FLUSH ? '0 : s_axis_tdata;
      dl_last[NL - 1] <= state != FLUSH && s_axis_tlast;
      dl_user[NL - 1] <= state == FLUSH ? '0 : user_in;
    end
  // Saturating statistics; a clear wins over any same-cycle increment
  always_ff @(posedge clk)
    if (rst || clear_counters) begin
      frame_count <= '0;
      drop_count <= '0;
      error_count <= '0;
    end else begin
      if (frame_inc && !(&frame_count)) frame_count <= frame_count + 1'b1;
      if (frame_inc && o_user[0] && !(&error_count)) error_count <= error_count + 1'b1;
      if (drop_inc && !(&drop_count)) drop_count <= drop_count + 1'b1;
    end
endmodule

// File: tb/tb_axis_rx_frame_gate.sv
// tb_axis_rx_frame_gate: directed frame table plus reset, overlap and counter corner sequences
module tb_axis_rx_frame_gate;
  localparam int N = 8;
  logic clk = 1'b0, rst, enable, clear_counters;
  logic [63:0] ts;
  logic [7:0] s_tdata, m_tdata, sm_tdata;
  logic s_tvalid, s_tlast, m_tvalid, m_tlast, sm_tvalid, sm_tlast, busy, s_busy;
  logic [0:0] s_tuser, m_tuser, sm_tuser;
  logic [31:0] frame_count, drop_count, error_count;
  logic [1:0] s_frame_count, s_drop_count, s_error_count;
  typedef struct {logic [7:0] d; logic l; logic u; int c;} beat_t;
  typedef struct {int len; int gap; bit en_start; int en_beat; bit en_after; bit bad; bit pass; logic [63:0] tsv; int f; int dr; int e;} row_t;
  beat_t q[$];
  row_t rows[8];
  int cyc = 0, s_beats = 0, s_lasts = 0, n_chk = 0, n_fail = 0;
  logic busy_first;

  axis_rx_frame_gate dut (
    .clk(clk), .rst(rst), .enable(enable), .ts(ts), .clear_counters(clear_counters),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .busy(busy), .frame_count(frame_count), .drop_count(drop_count), .error_count(error_count)
  );

  axis_rx_frame_gate #(.TS_ENABLE(0), .COUNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .ts(ts), .clear_counters(clear_counters),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(sm_tdata), .m_axis_tvalid(sm_tvalid), .m_axis_tlast(sm_tlast), .m_axis_tuser(sm_tuser),
    .busy(s_busy), .frame_count(s_frame_count), .drop_count(s_drop_count), .error_count(s_error_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (m_tvalid) begin
      b.d = m_tdata;
      b.l = m_tlast;
      b.u = m_tuser[0];
      b.c = cyc;
      q.push_back(b);
    end
    if (sm_tvalid) begin
      s_beats++;
      if (sm_tlast) s_lasts++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    repeat (n) tick;
  endtask

  task automatic send_frame(input int len, input int gap, input bit bad, input int en_beat, input bit en_after,
                            input int clr_beat, input int rst_beat, input logic [63:0] tsv);
    ts = tsv;
    for (int i = 0; i < len; i++) begin
      if (i == en_beat) enable = en_after;
      s_tvalid = 1'b1;
      s_tdata = i[7:0];
      s_tlast = i == len - 1;
      s_tuser = (i == len - 1) && bad;
      clear_counters = i == clr_beat;
      rst = i == rst_beat;
      tick;
      if (i == 0) busy_first = busy;
      ts = ~tsv;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      s_tuser = 1'b0;
      clear_counters = 1'b0;
      rst = 1'b0;
      if (gap > 1) repeat (gap - 1) tick;
    end
  endtask

  task automatic check_frame(input int len, input int gap, input bit bad, input bit pass, input logic [63:0] tsv);
    int ex;
    ex = pass ? len + N : 0;
    chk("busy_at_start", busy_first, pass);
    chk("busy_after", busy, 0);
    chk("out_beats", q.size(), ex);
    chk("plain_beats", s_beats, pass ? len : 0);
    chk("plain_lasts", s_lasts, pass ? 1 : 0);
    if (q.size() == ex)
      for (int j = 0; j < ex; j++) begin
        chk($sformatf("data[%0d]", j), q[j].d, j < N ? tsv[j*8 +: 8] : 8'(j - N));
        chk($sformatf("last_user[%0d]", j), {q[j].l, q[j].u}, {j == ex - 1, j == ex - 1 && bad});
        if (j > 0) chk($sformatf("spacing[%0d]", j), q[j].c - q[j-1].c, j < len ? gap : 1);
      end
    q.delete();
    s_beats = 0;
    s_lasts = 0;
  endtask

  task automatic chk_counts(input string nm, input int f, input int dr, input int e);
    chk({nm, "_frame_count"}, frame_count, f);
    chk({nm, "_drop_count"}, drop_count, dr);
    chk({nm, "_error_count"}, error_count, e);
  endtask

  initial begin
    rows[0] = '{64, 1, 1'b1, -1, 1'b1, 1'b0, 1'b1, 64'h0807060504030201, 1, 0, 0};
    rows[1] = '{64, 1, 1'b0,  5, 1'b1, 1'b0, 1'b0, 64'h1111111111111111, 1, 1, 0};
    rows[2] = '{64, 1, 1'b1, -1, 1'b1, 1'b0, 1'b1, 64'h1122334455667788, 2, 1, 0};
    rows[3] = '{64, 1, 1'b1,  9, 1'b0, 1'b0, 1'b1, 64'hA5B6C7D8E9FA0B1C, 3, 1, 0};
    rows[4] = '{64, 1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 64'h2222222222222222, 3, 2, 0};
    rows[5] = '{64, 2, 1'b1, -1, 1'b1, 1'b1, 1'b1, 64'hF0E1D2C3B4A59687, 4, 2, 1};
    rows[6] = '{ 3, 1, 1'b1, -1, 1'b1, 1'b0, 1'b1, 64'h0123456789ABCDEF, 5, 2, 1};
    rows[7] = '{ 1, 1, 1'b1, -1, 1'b1, 1'b1, 1'b1, 64'h5A5A3C3C96966969, 6, 2, 2};
    rst = 1'b1;
    enable = 1'b1;
    clear_counters = 1'b0;
    ts = '0;
    s_tdata = 8'hEE;
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    s_tuser = 1'b1;
    repeat (3) tick;
    chk("reset_out", {m_tvalid, m_tlast, m_tuser, m_tdata}, 0);
    chk("reset_busy", busy, 0);
    chk_counts("reset", 0, 0, 0);
    chk("reset_plain_counts", {s_frame_count, s_drop_count, s_error_count}, 0);
    rst = 1'b0;
    idle(4);
    q.delete();
    s_beats = 0;
    s_lasts = 0;
    for (int r = 0; r < 8; r++) begin
      if (r > 0) begin
        enable = rows[r].en_start;
        idle(3);
      end
      send_frame(rows[r].len, rows[r].gap, rows[r].bad, rows[r].en_beat, rows[r].en_after, -1, -1, rows[r].tsv);
      idle(14);
      check_frame(rows[r].len, rows[r].gap, rows[r].bad, rows[r].pass, rows[r].tsv);
      chk_counts($sformatf("row%0d", r), rows[r].f, rows[r].dr, rows[r].e);
    end
    enable = 1'b1;
    idle(3);
    send_frame(64, 1, 1'b0, -1, 1'b1, -1, 20, 64'h1234);
    idle(14);
    chk("rst_mid_beats", q.size(), 20);
    chk("rst_mid_tlasts", q.size() > 0 && (q[$].l || q[0].l), 0);
    chk_counts("rst_mid", 0, 0, 0);
    chk("rst_mid_busy", busy, 0);
    q.delete();
    s_beats = 0;
    s_lasts = 0;
    send_frame(64, 1, 1'b0, -1, 1'b1, -1, -1, 64'hCAFEF00DDEADBEEF);
    idle(14);
    check_frame(64, 1, 1'b0, 1'b1, 64'hCAFEF00DDEADBEEF);
    chk_counts("after_rst", 1, 0, 0);
    send_frame(2, 1, 1'b0, -1, 1'b1, -1, -1, 64'h8877665544332211);
    idle(2);
    send_frame(4, 1, 1'b0, -1, 1'b1, -1, -1, 64'h0);
    idle(14);
    chk("overlap_beats", q.size(), 10);
    chk_counts("overlap", 2, 1, 0);
    q.delete();
    clear_counters = 1'b1;
    tick;
    clear_counters = 1'b0;
    chk_counts("clear", 0, 0, 0);
    chk("clear_plain", {s_frame_count, s_drop_count, s_error_count}, 0);
    for (int k = 0; k < 4; k++) begin
      send_frame(2, 1, 1'b1, -1, 1'b1, -1, -1, 64'h0);
      idle(12);
    end
    chk_counts("four_bad", 4, 0, 4);
    chk("sat_frame", s_frame_count, 3);
    chk("sat_error", s_error_count, 3);
    enable = 1'b0;
    idle(3);
    for (int k = 0; k < 4; k++) begin
      send_frame(2, 1, 1'b0, -1, 1'b0, -1, -1, 64'h0);
      idle(12);
    end
    chk_counts("four_drop", 4, 4, 4);
    chk("sat_drop", s_drop_count, 3);
    send_frame(2, 1, 1'b0, -1, 1'b0, 1, -1, 64'h0);
    idle(12);
    chk_counts("clr_on_drop", 0, 0, 0);
    chk("clr_on_drop_plain", {s_frame_count, s_drop_count, s_error_count}, 0);
    enable = 1'b1;
    idle(3);
    send_frame(2, 1, 1'b1, -1, 1'b1, 1, -1, 64'h0);
    idle(12);
    chk_counts("clr_on_last", 1, 0, 1);
    chk("clr_on_last_plain", {s_frame_count, s_error_count}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
